ultrasonic_echo_meter: RTL and testbench
========================================

# ultrasonic_echo_meter

Drives the HC-SR04-style ultrasonic ranger: issues periodic trigger pulses, synchronizes and times the returned echo pulse in `clk` cycles, and presents the latest width as `echo_cnt`. Sits directly upstream of the LCD distance display, which converts `echo_cnt` to BCD and shows it on line 2. It is also the distance source for obstacle logic elsewhere on the car.

## Interface
Parameters:
- `TRIG_CYCLES`, default 500: trigger high width in cycles (10 µs at 50 MHz).
- `PERIOD_CYCLES`, default 3_000_000: trigger rising-edge spacing in cycles (60 ms).
- `TIMEOUT_CYCLES`, default 1_500_000: max wait for echo rise, and max echo high width (30 ms each).

Ports:
- `clk`, input, 1: system clock, 50 MHz.
- `reset`, input, 1: asynchronous, active-high reset.
- `echo`, input, 1: raw echo pin, asynchronous to `clk`.
- `trig`, output, 1: trigger pin to the sensor.
- `echo_cnt`, output, 32: last valid echo width in cycles. Held between measurements.
- `valid`, output, 1: one-cycle pulse when `echo_cnt` updates.
- `err`, output, 1: high after a timeout. Cleared by the next valid measurement.

## Operation
- `echo` passes through a 2-flop synchronizer, giving `echo_s`. Rise and fall are detected against a third registered copy.
- The FSM has four states:
  - IDLE: `trig`=0. Waits for the period counter to reach `PERIOD_CYCLES`-1, then goes to TRIG.
  - TRIG: `trig`=1 for exactly `TRIG_CYCLES` cycles, then goes to WAIT_RISE.
  - WAIT_RISE: a rise on `echo_s` loads width=1 and goes to MEASURE. If the wait counter reaches `TIMEOUT_CYCLES`, go to IDLE with a timeout.
  - MEASURE: width increments each cycle `echo_s`=1.
    - Fall: `echo_cnt`<=width, `valid`=1, `err`=0, go to IDLE.
    - Width reaching `TIMEOUT_CYCLES`: timeout, go to IDLE.
- On timeout, `echo_cnt` holds its previous value, `err` is set to 1, and `valid` does not pulse.
- `echo_s` already high when entering WAIT_RISE is not a rise. The block waits for a 0->1 transition.
- The period counter restarts at 0 on every entry to TRIG.
- If the counter expires while the FSM is not in IDLE, the trigger is deferred until IDLE is entered, and TRIG starts the next cycle.
- Width arithmetic is 32-bit unsigned and cannot overflow, since it is bounded by `TIMEOUT_CYCLES` < 2^32.
- `echo` transitions during TRIG or IDLE are ignored.

## Timing
- Reset values: FSM=IDLE, `trig`=0, `echo_cnt`=0, `valid`=0, `err`=0, period counter=`PERIOD_CYCLES`-1.
  - Consequently, the first trigger rises on the 2nd clock edge after reset deasserts.
- `trig` rising edges are exactly `PERIOD_CYCLES` apart whenever each measurement completes within the period.
- An echo held high for N cycles at the pin gives `echo_cnt`=N, exact for synchronous stimulus.
- `valid` and the `echo_cnt` update occur 3 clock edges after the first edge that samples `echo` low: 2 synchronizer edges plus 1 register edge.
- `valid` is never high for more than one cycle, and `err` and `valid` are never high in the same cycle.
- Reset asserted mid-measurement forces all reset values immediately. No partial width is published.

## Structure
- A shared package `ultrasonic_pkg` holds:
  - the FSM state enum (IDLE, TRIG, WAIT_RISE, MEASURE);
  - default timing constants for a 50 MHz clock;
  - the `ECHO_CNT_W`=32 width constant, which is shared with the LCD display.
- One sub-module, `echo_sync`, provides the 2-flop synchronizer plus rise/fall pulse outputs, reset to 0.
- The FSM, counters, and output registers live in the top.

## Test plan
All scenarios use small parameters: `TRIG_CYCLES`=10, `PERIOD_CYCLES`=200, `TIMEOUT_CYCLES`=100.
- Reset release, `echo` held at 0:
  - `trig` goes high on edge 2 for 10 cycles, with rising edges every 200 cycles.
  - `err`=1 after the first wait of 100 cycles; `echo_cnt` stays 0 and `valid` never pulses.
- Echo pulse of 37 cycles starting 5 cycles after `trig` falls -> `echo_cnt`=37, a single `valid` pulse 3 edges after `echo` falls, `err`=0.
- Timeout followed by a good 20-cycle echo on the next period -> `err` goes 1 then 0 with `valid`, and `echo_cnt`=20.
- `echo` stuck high for 150 cycles -> timeout at width 100, `echo_cnt` unchanged from its prior value (e.g. 37), `err`=1.
- `echo` already high when `trig` falls, then low, then a 12-cycle pulse -> `echo_cnt`=12.
- `reset` asserted for 1 cycle mid-MEASURE -> all outputs return to reset values at once, and the next `trig` rises 2 edges after release.

Source files
------------

// File: rtl/ultrasonic_pkg.sv
// Shared types and constants for the ultrasonic ranger and its consumers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ultrasonic_pkg;

    // Width of the published echo count; the LCD display sizes its converter from this.
    localparam int ECHO_CNT_W = 32;

    // Timing defaults for a 50 MHz core clock.
    localparam int unsigned DEF_TRIG_CYCLES    = 500;        // 10 us trigger pulse
    localparam int unsigned DEF_PERIOD_CYCLES  = 3_000_000;  // 60 ms between triggers
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1_500_000;  // 30 ms echo wait / width cap

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_TRIG      = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_MEASURE   = 2'd3
    } meter_state_e;

endpackage

// File: rtl/ultrasonic_echo_meter_echo_sync.sv
// Two-flop synchronizer for the raw echo pin with rise/fall pulses against a third copy.
// Latency: echo_s lags the pin by 2 edges; rise/fall are valid in the same cycle as echo_s.
// Backpressure: none; free-running.
module echo_sync (
    input  logic clk,
    input  logic reset,
    input  logic echo,
    output logic echo_s,
    output logic rise,
    output logic fall
);

    logic meta;
    logic echo_d;

    // Synchronizer chain plus one delayed copy for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            meta   <= echo;
            echo_s <= meta;
            echo_d <= echo_s;
        end
    end

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

endmodule

// File: rtl/ultrasonic_echo_meter.sv
// Periodic trigger generator and echo-width timer for an HC-SR04-style ranger.
// Latency: echo_cnt/valid update 3 edges after the pin is first sampled low.
// Backpressure: none; valid is a single-cycle strobe, echo_cnt holds until the next one.
module ultrasonic_echo_meter
    import ultrasonic_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  echo,
    output logic                  trig,
    output logic [ECHO_CNT_W-1:0] echo_cnt,
    output logic                  valid,
    output logic                  err
);

    localparam logic [ECHO_CNT_W-1:0] ONE          = 1;
    localparam logic [ECHO_CNT_W-1:0] PERIOD_LAST  = PERIOD_CYCLES - 1;
    localparam logic [ECHO_CNT_W-1:0] TRIG_LAST    = TRIG_CYCLES - 1;
    localparam logic [ECHO_CNT_W-1:0] TIMEOUT_LAST = TIMEOUT_CYCLES - 1;
    localparam logic [ECHO_CNT_W-1:0] TIMEOUT_MAX  = TIMEOUT_CYCLES;

    meter_state_e          state;
    logic [ECHO_CNT_W-1:0] period_cnt;
    logic [ECHO_CNT_W-1:0] tmr;
    logic [ECHO_CNT_W-1:0] width;
    logic                  period_done;
    logic                  start_trig;
    logic                  echo_s;
    logic                  echo_rise;
    logic                  echo_fall;

    echo_sync u_echo_sync (
        .clk    (clk),
        .reset  (reset),
        .echo   (echo),
        .echo_s (echo_s),
        .rise   (echo_rise),
        .fall   (echo_fall)
    );

    // The period counter parks at its last value, so an expiry seen outside IDLE
    // is remembered and fires as soon as the FSM returns to IDLE.
    assign period_done = (period_cnt == PERIOD_LAST);
    assign start_trig  = (state == ST_IDLE) && period_done;

    // Period counter: restarts on every trigger, saturates at expiry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            period_cnt <= PERIOD_LAST;
        end else if (start_trig) begin
            period_cnt <= '0;
        end else if (!period_done) begin
            period_cnt <= period_cnt + ONE;
        end
    end

    // Measurement FSM: trigger, wait for echo rise, time the echo, publish or time out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            tmr      <= '0;
            width    <= '0;
            echo_cnt <= '0;
            valid    <= 1'b0;
            err      <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_trig) begin
                        state <= ST_TRIG;
                        tmr   <= '0;
                    end
                end
                ST_TRIG: begin
                    if (tmr == TRIG_LAST) begin
                        state <= ST_WAIT_RISE;
                        tmr   <= '0;
                    end else begin
                        tmr <= tmr + ONE;
                    end
                end
                ST_WAIT_RISE: begin
                    // A level already high on entry produces no rise pulse, so it is ignored.
                    if (echo_rise) begin
                        width <= ONE;
                        state <= ST_MEASURE;
                    end else if (tmr == TIMEOUT_LAST) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        tmr <= tmr + ONE;
                    end
                end
                ST_MEASURE: begin
                    if (echo_fall) begin
                        echo_cnt <= width;
                        valid    <= 1'b1;
                        err      <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (width == TIMEOUT_MAX) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end else if (echo_s) begin
                        width <= width + ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Trigger pin is a registered copy of the TRIG state, high for TRIG_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig <= 1'b0;
        end else begin
            trig <= (state == ST_TRIG);
        end
    end

endmodule

// File: tb/tb_ultrasonic_echo_meter.sv
// Self-checking bench: randomized echo pulses per trigger period, scoreboard of expected publishes.
// Latency: expected publish 3 edges after the pin is first sampled low.
// Backpressure: n/a.
module tb_ultrasonic_echo_meter;

    localparam int unsigned TRIG_C    = 10;
    localparam int unsigned PERIOD_C  = 200;
    localparam int unsigned TIMEOUT_C = 100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        echo = 1'b0;
    logic        trig;
    logic [31:0] echo_cnt;
    logic        valid;
    logic        err;

    ultrasonic_echo_meter #(
        .TRIG_CYCLES    (TRIG_C),
        .PERIOD_CYCLES  (PERIOD_C),
        .TIMEOUT_CYCLES (TIMEOUT_C)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .echo     (echo),
        .trig     (trig),
        .echo_cnt (echo_cnt),
        .valid    (valid),
        .err      (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        int cnt;
        int at;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference state: what echo_cnt and err must show once a period has finished.
    logic model_err = 1'b0;
    int   model_cnt = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Publish monitor: each valid pulse must match the oldest expected measurement.
    always @(negedge clk) begin
        if (!reset && valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_valid: echo_cnt=%0d at cycle %0d, none expected", echo_cnt, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("valid_cnt", echo_cnt, mon_e.cnt);
                check("valid_cycle", cyc, mon_e.at);
                check("valid_err", err, 0);
            end
        end
    end

    // Trigger monitor: pulse width and rise-to-rise spacing.
    logic trig_q = 1'b0;
    bit   have_prev = 1'b0;
    int   last_rise = 0;
    always @(negedge clk) begin
        if (reset) begin
            have_prev = 1'b0;
        end else begin
            if (trig && !trig_q) begin
                if (have_prev) check("trig_period", cyc - last_rise, PERIOD_C);
                have_prev = 1'b1;
                last_rise = cyc;
            end
            if (!trig && trig_q) check("trig_width", cyc - last_rise, TRIG_C);
        end
        trig_q = trig;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_trig(input logic lvl);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (trig === lvl) return;
        end
        n_cmp++;
        n_fail++;
        $display("FAIL trig_wait: trig did not reach %0b within 400 cycles", lvl);
    endtask

    // Echo pulse of n cycles, starting d cycles after the current point.
    task automatic pulse(input int d, input int n);
        int   c;
        exp_t e;
        step(d);
        echo = 1'b1;
        c = cyc;
        step(n);
        echo = 1'b0;
        if (n < int'(TIMEOUT_C)) begin
            e.cnt = n;
            e.at  = c + n + 3;
            exp_q.push_back(e);
            model_cnt = n;
            model_err = 1'b0;
        end else begin
            model_err = 1'b1;
        end
    endtask

    // One trigger period; entered just after trig rises, leaves just after the next rise.
    // kind: 0 silent, 1 pulse, 2 echo pre-high then pulse, 3 reset mid-measure.
    task automatic run_period(input int kind, input int d, input int n);
        int r;
        check("period_err", err, model_err);
        check("period_cnt", echo_cnt, model_cnt);
        case (kind)
            0: begin
                model_err = 1'b1;
                wait_trig(1'b0);
            end
            1: begin
                wait_trig(1'b0);
                pulse(d, n);
            end
            2: begin
                echo = 1'b1;
                wait_trig(1'b0);
                step(3);
                echo = 1'b0;
                step(4);
                pulse(1, n);
            end
            default: begin
                wait_trig(1'b0);
                step(d);
                echo = 1'b1;
                step(20);
                reset = 1'b1;
                #1;
                check("rst_trig", trig, 0);
                check("rst_cnt", echo_cnt, 0);
                check("rst_valid", valid, 0);
                check("rst_err", err, 0);
                @(posedge clk);
                #1;
                reset = 1'b0;
                echo = 1'b0;
                r = cyc;
                model_err = 1'b0;
                model_cnt = 0;
                wait_trig(1'b1);
                check("rst_trig_rise", cyc - r, 2);
                return;
            end
        endcase
        wait_trig(1'b1);
    endtask

    initial begin
        int r;
        int k;
        int d;
        int n;
        @(negedge clk);
        @(negedge clk);
        check("reset_trig", trig, 0);
        check("reset_cnt", echo_cnt, 0);
        check("reset_valid", valid, 0);
        check("reset_err", err, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        r = cyc;
        wait_trig(1'b1);
        check("first_trig_rise", cyc - r, 2);

        // Directed: silence, good pulse, timeout then good, stuck high, pre-high, reset.
        run_period(0, 0, 0);
        run_period(1, 5, 37);
        run_period(0, 0, 0);
        run_period(1, 5, 20);
        run_period(1, 5, 37);
        run_period(1, 3, 150);
        run_period(2, 0, 12);
        run_period(1, 5, 60);
        run_period(3, 5, 0);

        // Randomized periods.
        for (int i = 0; i < 12; i++) begin
            k = int'($urandom_range(0, 3));
            d = int'($urandom_range(1, 20));
            case (k)
                0: run_period(0, 0, 0);
                1: begin
                    n = int'($urandom_range(1, 95));
                    run_period(1, d, n);
                end
                2: begin
                    n = int'($urandom_range(105, 160));
                    run_period(1, d, n);
                end
                default: begin
                    n = int'($urandom_range(1, 60));
                    run_period(2, 0, n);
                end
            endcase
        end
        check("final_err", err, model_err);
        check("final_cnt", echo_cnt, model_cnt);
        step(5);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
